// File: rtl/column_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : column_feeder_pkg
// Brief   : Shared column width, FSM state encoding and FIFO entry layout.
// Revision: 1.0
// ============================================================================
package column_feeder_pkg;

  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  typedef struct packed {
    logic             sof;
    logic [COL_W-1:0] col;
  } col_entry_t;

endpackage
`default_nettype wire

// File: rtl/column_fifo.sv
`default_nettype none
// ============================================================================
// Module  : column_fifo
// Brief   : DEPTH-entry synchronous FIFO of {sof,col} entries, no fall-through.
// Revision: 1.0
// ============================================================================
module column_fifo
  import column_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_push,
  input  logic [COL_W:0] i_data,
  input  logic           i_pop,
  output logic [COL_W:0] o_head,
  output logic           o_empty,
  output logic           o_full
);

  localparam int            c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(DEPTH);

  logic [COL_W:0]      r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;

  logic w_push;
  logic w_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_push  = i_push & ~o_full & ~reset;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_full_count);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/column_feeder.sv
`default_nettype none
// ============================================================================
// Module  : column_feeder
// Brief   : Buffers glyph columns and feeds the reader one column/restart per
//           clock, inserting restarts at frame starts and blank filler on
//           underrun. Optional: COLUMN_FEEDER_UNDERRUN_CNT_EN adds underrun_cnt.
// Revision: 1.0
// ============================================================================
module column_feeder
  import column_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COL_W-1:0] in_col,
  input  logic             in_sof,
  output logic [COL_W-1:0] out_bits,
  output logic             out_restart,
  output logic             out_valid
`ifdef COLUMN_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COL_W-1:0] r_bits;
  logic             r_restart;
  logic             r_valid;
  logic [COL_W-1:0] w_bits_nxt;
  logic             w_restart_nxt;
  logic             w_valid_nxt;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [COL_W:0]   w_head_raw;
  col_entry_t       w_head;
  col_entry_t       w_in_entry;

  assign in_ready   = ~w_full & ~reset;
  assign w_in_entry = '{sof: in_sof, col: in_col};
  assign w_head     = col_entry_t'(w_head_raw);

  column_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid & in_ready),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_head  (w_head_raw),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_bits_nxt    = '0;
    w_restart_nxt = 1'b0;
    w_valid_nxt   = 1'b0;
    case (r_state)
      S_HOLD: begin
        w_restart_nxt = 1'b1;
        if (!w_empty) begin
          if (w_head.sof) begin
            w_state_nxt = S_ARM;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      S_ARM: begin
        // The sof head is never popped before ARM, so it is still present here.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_bits_nxt  = w_head.col;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_STREAM;
        end else begin
          w_restart_nxt = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_empty) begin
          w_state_nxt = S_STREAM;
        end else if (w_head.sof) begin
          w_restart_nxt = 1'b1;
          w_state_nxt   = S_ARM;
        end else begin
          w_pop       = 1'b1;
          w_bits_nxt  = w_head.col;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_restart_nxt = 1'b1;
        w_state_nxt   = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bits    <= '0;
      r_restart <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      r_bits    <= w_bits_nxt;
      r_restart <= w_restart_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign out_bits    = r_bits;
  assign out_restart = r_restart;
  assign out_valid   = r_valid;

`ifdef COLUMN_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun_cnt <= '0;
    end else if ((r_state == S_STREAM) && w_empty && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_column_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_column_feeder
// Brief   : Scoreboarded random + directed bench for column_feeder.
// Revision: 1.0
// ============================================================================
module tb_column_feeder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_col;
  logic       in_sof;
  logic [2:0] out_bits;
  logic       out_restart;
  logic       out_valid;
`ifdef COLUMN_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  column_feeder #(
    .DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_col      (in_col),
    .in_sof      (in_sof),
    .out_bits    (out_bits),
    .out_restart (out_restart),
    .out_valid   (out_valid)
`ifdef COLUMN_FEEDER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Columns the reader must eventually see, in order, tagged with frame start.
  typedef struct {
    logic       sof;
    logic [2:0] col;
  } exp_t;
  exp_t exp_q[$];

  // Sampled directed observations, compared and counted by the monitor.
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req;
  } dchk_t;
  dchk_t dq[$];

  int   checks = 0;
  int   errors = 0;
  logic in_frame = 1'b0;
  logic prev_restart = 1'b1;
  logic mon_en = 1'b0;

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] r);
    dq.push_back('{name: n, act: a, req: r});
  endtask

  task automatic post_out(input string n, input logic r, input logic v, input logic [2:0] b);
    post({n, "_restart"}, {31'd0, out_restart}, {31'd0, r});
    post({n, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    post({n, "_bits"}, {29'd0, out_bits}, {29'd0, b});
  endtask

  // One clock: drive after the falling edge, record acceptance into the model.
  task automatic cycle(input logic rst, input logic v, input logic s, input logic [2:0] c);
    @(negedge clk);
    #1;
    reset    = rst;
    in_valid = v;
    in_sof   = s;
    in_col   = c;
    if (rst) begin
      exp_q.delete();
      in_frame = 1'b0;
    end
    #1;
    if (v && in_ready && !rst) begin
      if (s) in_frame = 1'b1;
      if (in_frame) exp_q.push_back('{sof: s, col: c});
    end
  endtask

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", n, a, r);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t  e;
      dchk_t d;
      while (dq.size() != 0) begin
        d = dq.pop_front();
        cmp(d.name, d.act, d.req);
      end
      cmp("restart_with_valid", {31'd0, out_restart & out_valid}, 32'd0);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_column", {29'd0, out_bits}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          cmp("column", {29'd0, out_bits}, {29'd0, e.col});
          cmp("restart_before_column", {31'd0, prev_restart}, {31'd0, e.sof});
        end
      end
      prev_restart = out_restart;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_full;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_col   = 3'd0;

    // Reset, then idle.
    cycle(1, 0, 0, 0);
    mon_en = 1'b1;
    cycle(1, 0, 0, 0);
    post("ready_in_reset", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      post_out("idle_hold", 1, 0, 3'd0);
      post("ready_after_reset", {31'd0, in_ready}, 32'd1);
    end

    // First frame: restart until the sof column is decoded, then 3 columns.
    cycle(0, 1, 1, 3'b111);
    cycle(0, 1, 0, 3'b001);
    post_out("f1_wait1", 1, 0, 3'd0);
    cycle(0, 1, 0, 3'b000);
    post_out("f1_wait2", 1, 0, 3'd0);
    cycle(0, 0, 0, 0);
    post_out("f1_col0", 0, 1, 3'b111);
    cycle(0, 0, 0, 0);
    post_out("f1_col1", 0, 1, 3'b001);
    cycle(0, 0, 0, 0);
    post_out("f1_col2", 0, 1, 3'b000);
    cycle(0, 0, 0, 0);
    post_out("f1_filler", 0, 0, 3'd0);

    // Two columns then a new frame: exactly one restart cycle in between.
    cycle(0, 1, 0, 3'b010);
    cycle(0, 1, 0, 3'b011);
    post_out("f2_filler", 0, 0, 3'd0);
    cycle(0, 1, 1, 3'b111);
    post_out("f2_col0", 0, 1, 3'b010);
    cycle(0, 0, 0, 0);
    post_out("f2_col1", 0, 1, 3'b011);
    cycle(0, 0, 0, 0);
    post_out("f2_restart", 1, 0, 3'd0);
    cycle(0, 0, 0, 0);
    post_out("f3_col0", 0, 1, 3'b111);

    // Orphan columns in HOLD are discarded.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, (i < 3), 0, 3'(i + 5));
      post_out("orphan_hold", 1, 0, 3'd0);
    end

    // Back-to-back sof columns drain at half rate and fill the FIFO.
    cycle(1, 0, 0, 0);
    saw_full = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 1, 3'($urandom_range(0, 7)));
      if (!in_ready) saw_full = 1'b1;
    end
    post("fifo_reached_full", {31'd0, saw_full}, 32'd1);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    post("full_drain_empty", exp_q.size(), 32'd0);

`ifdef COLUMN_FEEDER_UNDERRUN_CNT_EN
    // Starve the stream for ten cycles.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 3'b101);
    for (int k = 1; k <= 13; k++) begin
      cycle(0, 0, 0, 0);
      if (k >= 4) post_out("starve_filler", 0, 0, 3'd0);
    end
    post("underrun_cnt_10", {16'd0, underrun_cnt}, 32'd10);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    post("underrun_cnt_reset", {16'd0, underrun_cnt}, 32'd0);
    cycle(0, 0, 0, 0);
    post("underrun_cnt_hold", {16'd0, underrun_cnt}, 32'd0);
`endif

    // Random traffic with occasional mid-frame resets.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 65),
            ($urandom_range(0, 99) < 15),
            3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    post("random_drain_empty", exp_q.size(), 32'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
